// File: rtl/angle_force_accumulator_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : angle_force_accumulator_if
// Purpose  : Record-in / force-read bundle between the angle force core,
//            the force accumulator and the integrator.
// Revision : 1.0  initial release
// ============================================================================
interface angle_force_accumulator_if #(
    parameter int IDX_W = 4
);
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] idx_a;
    logic [IDX_W-1:0] idx_b;
    logic [IDX_W-1:0] idx_c;
    logic [31:0]      fax;
    logic [31:0]      fay;
    logic [31:0]      faz;
    logic [31:0]      fbx;
    logic [31:0]      fby;
    logic [31:0]      fbz;
    logic [31:0]      fcx;
    logic [31:0]      fcy;
    logic [31:0]      fcz;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_fx;
    logic [31:0]      rd_fy;
    logic [31:0]      rd_fz;
    logic             busy;
    logic             drop_err;
    logic             sat_err;
    logic             idx_err;

    // Producer / integrator side
    modport master (
        output clear, in_valid, idx_a, idx_b, idx_c,
               fax, fay, faz, fbx, fby, fbz, fcx, fcy, fcz, rd_idx,
        input  in_ready, rd_fx, rd_fy, rd_fz, busy, drop_err, sat_err, idx_err
    );

    // Accumulator side
    modport slave (
        input  clear, in_valid, idx_a, idx_b, idx_c,
               fax, fay, faz, fbx, fby, fbz, fcx, fcy, fcz, rd_idx,
        output in_ready, rd_fx, rd_fy, rd_fz, busy, drop_err, sat_err, idx_err
    );
endinterface
`default_nettype wire

// File: rtl/angle_force_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : angle_force_accumulator
// Purpose  : Scatter-adds per-angle Q16.16 forces (atoms A/B/C) into a
//            per-atom force register file, with an input FIFO, saturating
//            adds, a sweeping clear and a registered read port.
// Revision : 1.0  initial release
// ============================================================================
module angle_force_accumulator #(
    parameter int NUM_ATOMS  = 16,
    parameter int IDX_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    angle_force_accumulator_if.slave bus
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_aw    = (NUM_ATOMS > 1) ? $clog2(NUM_ATOMS) : 1;
    localparam int c_frc_w = 9 * 32;
    localparam int c_rec_w = 3 * IDX_W + c_frc_w;

    localparam logic [c_ptr_w:0] c_depth     = (c_ptr_w+1)'(FIFO_DEPTH);
    localparam logic [IDX_W:0]   c_num_atoms = (IDX_W+1)'(NUM_ATOMS);
    localparam logic [c_aw-1:0]  c_last      = c_aw'(NUM_ATOMS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC_A = 3'd1,
        S_ACC_B = 3'd2,
        S_ACC_C = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    // Two's-complement add on a 33-bit intermediate; MSB of the result flags a clamp.
    function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31])
            return {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        else
            return {1'b0, s[31:0]};
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [c_rec_w-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic [31:0]        r_acc_x [NUM_ATOMS];
    logic [31:0]        r_acc_y [NUM_ATOMS];
    logic [31:0]        r_acc_z [NUM_ATOMS];

    state_t             r_state;
    logic [c_aw-1:0]    r_ptr;
    logic               r_clear_pend;
    logic               r_drop_err;
    logic               r_sat_err;
    logic               r_idx_err;

    // Working copy of the record being applied (f[0..8] = fax..fcz)
    logic [IDX_W-1:0]   r_wk_idx_a;
    logic [IDX_W-1:0]   r_wk_idx_b;
    logic [IDX_W-1:0]   r_wk_idx_c;
    logic [31:0]        r_wk_f [9];

    logic [31:0]        r_rd_fx;
    logic [31:0]        r_rd_fy;
    logic [31:0]        r_rd_fz;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [c_rec_w-1:0] w_in_rec;
    logic [c_rec_w-1:0] w_fifo_out;

    assign w_full     = (r_count == c_depth);
    assign w_empty    = (r_count == '0);
    assign w_push     = bus.in_valid && !w_full;
    assign w_drop     = bus.in_valid && w_full;
    // A pending clear blocks new pops; the record in flight finishes first.
    assign w_pop      = (r_state == S_IDLE) && !r_clear_pend && !w_empty;
    assign w_in_rec   = {bus.idx_a, bus.idx_b, bus.idx_c,
                         bus.fax, bus.fay, bus.faz,
                         bus.fbx, bus.fby, bus.fbz,
                         bus.fcx, bus.fcy, bus.fcz};
    assign w_fifo_out = r_fifo_mem[r_rd_ptr];

    // FIFO payload write (no reset needed; validity comes from r_count)
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo_mem[r_wr_ptr] <= w_in_rec;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read-modify-write datapath for the current atom step
    // ------------------------------------------------------------------
    logic             w_step;
    logic [IDX_W-1:0] w_step_idx;
    logic [c_aw-1:0]  w_step_addr;
    logic             w_step_ok;
    logic [31:0]      w_fx;
    logic [31:0]      w_fy;
    logic [31:0]      w_fz;
    logic [31:0]      w_cur_x;
    logic [31:0]      w_cur_y;
    logic [31:0]      w_cur_z;
    logic [32:0]      w_sx;
    logic [32:0]      w_sy;
    logic [32:0]      w_sz;
    logic             w_sat_hit;
    logic             w_idx_bad;

    // Pick the atom index and force triple for the active step
    always_comb begin
        w_step     = 1'b0;
        w_step_idx = '0;
        w_fx       = '0;
        w_fy       = '0;
        w_fz       = '0;
        case (r_state)
            S_ACC_A: begin
                w_step = 1'b1; w_step_idx = r_wk_idx_a;
                w_fx = r_wk_f[0]; w_fy = r_wk_f[1]; w_fz = r_wk_f[2];
            end
            S_ACC_B: begin
                w_step = 1'b1; w_step_idx = r_wk_idx_b;
                w_fx = r_wk_f[3]; w_fy = r_wk_f[4]; w_fz = r_wk_f[5];
            end
            S_ACC_C: begin
                w_step = 1'b1; w_step_idx = r_wk_idx_c;
                w_fx = r_wk_f[6]; w_fy = r_wk_f[7]; w_fz = r_wk_f[8];
            end
            default: ;
        endcase
    end

    assign w_step_addr = w_step_idx[c_aw-1:0];
    assign w_step_ok   = ({1'b0, w_step_idx} < c_num_atoms);
    assign w_cur_x     = w_step_ok ? r_acc_x[w_step_addr] : '0;
    assign w_cur_y     = w_step_ok ? r_acc_y[w_step_addr] : '0;
    assign w_cur_z     = w_step_ok ? r_acc_z[w_step_addr] : '0;
    assign w_sx        = sat_add(w_cur_x, w_fx);
    assign w_sy        = sat_add(w_cur_y, w_fy);
    assign w_sz        = sat_add(w_cur_z, w_fz);
    assign w_sat_hit   = w_step && w_step_ok && (w_sx[32] || w_sy[32] || w_sz[32]);
    assign w_idx_bad   = w_step && !w_step_ok;

    // Force register file: step writes, clear sweep, async reset to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ATOMS; i++) begin
                r_acc_x[i] <= '0;
                r_acc_y[i] <= '0;
                r_acc_z[i] <= '0;
            end
        end else if (w_step && w_step_ok) begin
            r_acc_x[w_step_addr] <= w_sx[31:0];
            r_acc_y[w_step_addr] <= w_sy[31:0];
            r_acc_z[w_step_addr] <= w_sz[31:0];
        end else if (r_state == S_CLEAR) begin
            r_acc_x[r_ptr] <= '0;
            r_acc_y[r_ptr] <= '0;
            r_acc_z[r_ptr] <= '0;
        end
    end

    // Sequencer: pop, three RMW steps, clear sweep, sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_clear_pend <= 1'b0;
            r_drop_err   <= 1'b0;
            r_sat_err    <= 1'b0;
            r_idx_err    <= 1'b0;
            r_wk_idx_a   <= '0;
            r_wk_idx_b   <= '0;
            r_wk_idx_c   <= '0;
            for (int k = 0; k < 9; k++)
                r_wk_f[k] <= '0;
        end else begin
            if (w_drop)
                r_drop_err <= 1'b1;
            if (w_sat_hit)
                r_sat_err <= 1'b1;
            if (w_idx_bad)
                r_idx_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (r_clear_pend) begin
                        r_ptr   <= '0;
                        r_state <= S_CLEAR;
                    end else if (!w_empty) begin
                        r_wk_idx_a <= w_fifo_out[c_rec_w-1 -: IDX_W];
                        r_wk_idx_b <= w_fifo_out[c_rec_w-1-IDX_W -: IDX_W];
                        r_wk_idx_c <= w_fifo_out[c_rec_w-1-2*IDX_W -: IDX_W];
                        for (int k = 0; k < 9; k++)
                            r_wk_f[k] <= w_fifo_out[c_frc_w-1-32*k -: 32];
                        r_state <= S_ACC_A;
                    end
                end
                S_ACC_A: r_state <= S_ACC_B;
                S_ACC_B: r_state <= S_ACC_C;
                S_ACC_C: r_state <= S_IDLE;
                S_CLEAR: begin
                    if (r_ptr == c_last) begin
                        r_clear_pend <= 1'b0;
                        r_drop_err   <= 1'b0;
                        r_sat_err    <= 1'b0;
                        r_idx_err    <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_ptr <= r_ptr + c_aw'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A new clear request always wins, even on the sweep's last cycle.
            if (bus.clear)
                r_clear_pend <= 1'b1;
        end
    end

    // Registered read port; out-of-range addresses read as zero
    logic             w_rd_ok;
    logic [c_aw-1:0]  w_rd_addr;
    assign w_rd_ok   = ({1'b0, bus.rd_idx} < c_num_atoms);
    assign w_rd_addr = bus.rd_idx[c_aw-1:0];

    // Capture the addressed entry (pre-update value on a same-cycle write)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_fx <= '0;
            r_rd_fy <= '0;
            r_rd_fz <= '0;
        end else begin
            r_rd_fx <= w_rd_ok ? r_acc_x[w_rd_addr] : '0;
            r_rd_fy <= w_rd_ok ? r_acc_y[w_rd_addr] : '0;
            r_rd_fz <= w_rd_ok ? r_acc_z[w_rd_addr] : '0;
        end
    end

    assign bus.in_ready = !w_full;
    assign bus.rd_fx    = r_rd_fx;
    assign bus.rd_fy    = r_rd_fy;
    assign bus.rd_fz    = r_rd_fz;
    assign bus.busy     = (r_state != S_IDLE) || !w_empty || r_clear_pend;
    assign bus.drop_err = r_drop_err;
    assign bus.sat_err  = r_sat_err;
    assign bus.idx_err  = r_idx_err;

endmodule
`default_nettype wire

// File: doc/angle_force_accumulator.md
Name: angle_force_accumulator

Overview:
- Downstream of the angle force core. It consumes each per-angle result: atom indices A/B/C plus the nine Q16.16 force components Fa, Fb, Fc.
- It scatter-adds the forces into a per-atom force register file of NUM_ATOMS entries × 3 components.
- A small input FIFO absorbs the core's single-cycle valid pulses, since the core has no back-pressure.
- The integrator reads the accumulated forces through a registered read port. A clear pulse zeroes all accumulators between timesteps.

Parameters:
- NUM_ATOMS, 16, number of atom force entries.
- IDX_W, 4, atom index width; must satisfy 2^IDX_W >= NUM_ATOMS.
- FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  pulse: zero all accumulators and sticky flags.
- in_valid  in  1  force record present (driven from the core's valid_out).
- in_ready  out  1  FIFO can accept this cycle.
- idx_a, idx_b, idx_c  in  IDX_W each  atom indices of the angle (B = vertex).
- fax, fay, faz, fbx, fby, fbz, fcx, fcy, fcz  in  32 each  signed Q16.16 forces.
- rd_idx  in  IDX_W  read address.
- rd_fx, rd_fy, rd_fz  out  32 each  signed accumulated force at rd_idx; registered.
- busy  out  1  FIFO non-empty, RMW in progress, or clear pending.
- drop_err  out  1  sticky: record arrived while FIFO full.
- sat_err  out  1  sticky: an accumulation saturated.
- idx_err  out  1  sticky: an index >= NUM_ATOMS.

Behaviour:
- Reset (async, rst=1):
  - state=S_IDLE, FIFO empty, all accumulators 0.
  - rd_f* = 0, in_ready = 1, busy = 0, all error flags 0, clear_pend = 0.
- Push:
  - When in_valid && in_ready, one record {idx_a..c, 9 forces} is written to the FIFO.
  - in_ready = !full. There is no same-cycle bypass of a pop on a full FIFO.
  - When in_valid && !in_ready, the record is discarded and drop_err is set.
- clear:
  - Latches clear_pend=1 in any state.
  - The clear executes only from S_IDLE and takes priority over FIFO pops. A record mid-RMW completes first.
  - Records already queued stay queued and are applied after the clear.
- FSM:
  - S_IDLE: if clear_pend, go to S_CLEAR with ptr=0. Else, if FIFO non-empty, pop into the working register and go to S_ACC_A. Else stay.
  - S_ACC_A: acc[idx_a] += (fax, fay, faz). Go to S_ACC_B.
  - S_ACC_B: acc[idx_b] += (fbx, fby, fbz). Go to S_ACC_C.
  - S_ACC_C: acc[idx_c] += (fcx, fcy, fcz). Go to S_IDLE.
  - S_CLEAR: acc[ptr] = 0 and ptr++. At ptr == NUM_ATOMS-1, also clear clear_pend, drop_err, sat_err and idx_err, then go to S_IDLE. Takes NUM_ATOMS cycles.
- Throughput and latency:
  - 4 cycles per record (pop plus 3 RMW).
  - A record pushed into an empty idle block is fully visible in the array 4 cycles after the push edge.
- Arithmetic:
  - Each component sum is computed to 33 bits and then saturated to 0x7FFFFFFF / 0x80000000.
  - Any clamp sets sat_err.
- Repeated indices (e.g. idx_a == idx_c): the sequential RMW sees the previous step's result, so both contributions are summed.
- An index >= NUM_ATOMS skips that atom's step (the cycle is still spent) and sets idx_err.
- Read port: rd_f* <= acc[rd_idx] each cycle (1-cycle latency). It returns the pre-update value if the same entry is written in that cycle. An out-of-range rd_idx returns 0.
- busy = (state != S_IDLE) || !empty || clear_pend.
- Reset asserted mid-RMW or mid-clear aborts immediately to reset values. Partially applied records are lost.

Test Plan:
- Single record:
  - Stimulus: idx=(0,1,2), Fa=(0x10000,0,0), Fb=(-0x20000,0,0), Fc=(0x10000,0,0).
  - Response: after busy falls, rd x-components are idx0=0x00010000, idx1=0xFFFE0000, idx2=0x00010000; busy is high for exactly 4 cycles.
- Accumulate and alias:
  - Stimulus: two records, both with idx_a=idx_c=3 and Fa.x=Fc.x=0x8000.
  - Response: acc[3].x=0x00020000.
- Saturation:
  - Stimulus: preload acc[5].y=0x7FFF0000 via a prior record, then add fay=0x00020000.
  - Response: acc[5].y=0x7FFFFFFF and sat_err=1.
- Burst and overflow:
  - Stimulus: in_valid held high for 6 consecutive cycles with FIFO_DEPTH=4.
  - Response: in_ready drops once the FIFO is full and drop_err=1. Only the accepted records are applied.
- Clear ordering:
  - Stimulus: pulse clear during S_ACC_B of record R1, with R2 queued.
  - Response: after clear completes, all entries except R2's atoms read 0, R2's atoms hold only R2's forces, and all flags are 0.
- Async reset:
  - Stimulus: assert rst mid-S_CLEAR.
  - Response: all outputs are at reset values within the same cycle; in_ready=1.
